// File: rtl/rv_plic_target_pkg.sv
// rv_plic_target_pkg
// Shared types and helpers for the per-target PLIC arbiter.
//   node_t       : one max-tree node (valid, id, prio), sized for up to
//                  2^NodeIdW sources and 2^NodePrioW priority levels.
//   prio_width   : bits needed to hold 0..MAX_PRIO.
//   src_width    : bits needed to hold a source ID.
//   depth_width  : bits needed to hold a stack occupancy 0..NEST_DEPTH.
//   tree_stages  : number of register stages P inside the max-tree.
//   node_max     : one tree node; higher prio wins, ties go to the lower ID.
package rv_plic_target_pkg;

  localparam int NodeIdW   = 16;
  localparam int NodePrioW = 8;

  typedef struct packed {
    logic                 valid;
    logic [NodeIdW-1:0]   id;
    logic [NodePrioW-1:0] prio;
  } node_t;

  function automatic int prio_width(input int max_prio);
    return (max_prio < 1) ? 1 : $clog2(max_prio + 1);
  endfunction

  function automatic int src_width(input int n_source);
    return $clog2(n_source);
  endfunction

  function automatic int depth_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int tree_stages(input int n_source, input int pipe_every);
    int levels;
    levels = $clog2(n_source);
    return (pipe_every == 0) ? 0 : (levels - 1) / pipe_every;
  endfunction

  // 'lo' is always the child covering the lower IDs, so keeping it on a
  // tie implements the lower-ID-wins rule.
  function automatic node_t node_max(input node_t lo, input node_t hi);
    node_t res;
    res = '0;
    if (lo.valid && hi.valid) begin
      res = (hi.prio > lo.prio) ? hi : lo;
    end else if (lo.valid) begin
      res = lo;
    end else if (hi.valid) begin
      res = hi;
    end
    return res;
  endfunction

endpackage

// File: rtl/rv_plic_prio_tree.sv
// rv_plic_prio_tree
// Binary max-tree over the qualified leaves. A register stage follows every
// PIPE_EVERY-th merge level below the root (the root itself is never
// registered here; the top level registers the final result).
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   leaf_valid_i  : per-source qualified pending bit (bit 0 ignored)
//   leaf_prio_i   : per-source priority, packed PRIO_W bits per source
//   root_o        : winning node
module rv_plic_prio_tree
  import rv_plic_target_pkg::*;
#(
  parameter int N_SOURCE   = 32,
  parameter int PRIO_W     = 3,
  parameter int PIPE_EVERY = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [N_SOURCE-1:0]        leaf_valid_i,
  input  logic [N_SOURCE*PRIO_W-1:0] leaf_prio_i,
  output node_t                      root_o
);

  localparam int Levels  = $clog2(N_SOURCE);
  localparam int NPad    = 1 << Levels;
  localparam int PipeDiv = (PIPE_EVERY > 0) ? PIPE_EVERY : 1;

  // ID 0 is reserved, so leaf 0 never competes.
  logic unused_leaf0;
  assign unused_leaf0 = ^{leaf_valid_i[0], leaf_prio_i[PRIO_W-1:0]};

  for (genvar gi = 0; gi <= Levels; gi++) begin : g_lvl
    localparam int Width = NPad >> gi;
    node_t nodes [Width];

    if (gi == 0) begin : g_leaf
      for (genvar gj = 0; gj < Width; gj++) begin : g_n
        if (gj == 0 || gj >= N_SOURCE) begin : g_pad
          assign nodes[gj] = '0;
        end else begin : g_src
          node_t leaf;
          always_comb begin
            leaf = '0;
            if (leaf_valid_i[gj]) begin
              leaf.valid = 1'b1;
              leaf.id    = NodeIdW'(gj);
              leaf.prio  = NodePrioW'(leaf_prio_i[gj*PRIO_W +: PRIO_W]);
            end
          end
          assign nodes[gj] = leaf;
        end
      end
    end else begin : g_merge
      for (genvar gj = 0; gj < Width; gj++) begin : g_n
        node_t node_d;
        assign node_d = node_max(g_lvl[gi-1].nodes[2*gj], g_lvl[gi-1].nodes[2*gj+1]);

        if (PIPE_EVERY > 0 && gi < Levels && (gi % PipeDiv) == 0) begin : g_reg
          node_t node_q;
          always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
              node_q <= '0;
            end else begin
              node_q <= node_d;
            end
          end
          assign nodes[gj] = node_q;
        end else begin : g_comb
          assign nodes[gj] = node_d;
        end
      end
    end
  end

  assign root_o = g_lvl[Levels].nodes[0];

endmodule

// File: rtl/rv_plic_target_cc.sv
// rv_plic_target_cc
// Per-target PLIC arbiter: max-tree selection, threshold compare against the
// target threshold (raised by the in-service priority when nesting), and
// claim/complete tracking through an in-service stack.
// Optional feature macro: RV_PLIC_TARGET_NEST_EN (priority-based nesting).
//   Undefined: a single in-service slot, no interrupt while busy.
// Ports:
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   ip_i, ie_i, prio_i      : pending, enable and priority per source
//   threshold_i             : target threshold
//   claim_i                 : claim strobe, answered on claim_id_o same cycle
//   complete_i/complete_id_i: complete strobe and the ID being completed
//   irq_o, irq_id_o         : registered request and winning ID
//   busy_o, depth_o         : stack non-empty, stack occupancy
//   cpl_err_o               : one-cycle pulse after a rejected complete
module rv_plic_target_cc
  import rv_plic_target_pkg::*;
#(
  parameter int N_SOURCE    = 32,
  parameter int MAX_PRIO    = 7,
  parameter int PIPE_EVERY  = 2,
  parameter int NEST_DEPTH  = 4,
  localparam int PrioWidth  = prio_width(MAX_PRIO),
  localparam int SrcWidth   = src_width(N_SOURCE),
  localparam int DepthWidth = depth_width(NEST_DEPTH)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_SOURCE-1:0]           ip_i,
  input  logic [N_SOURCE-1:0]           ie_i,
  input  logic [N_SOURCE*PrioWidth-1:0] prio_i,
  input  logic [PrioWidth-1:0]          threshold_i,
  input  logic                          claim_i,
  input  logic                          complete_i,
  input  logic [SrcWidth-1:0]           complete_id_i,
  output logic                          irq_o,
  output logic [SrcWidth-1:0]           irq_id_o,
  output logic [SrcWidth-1:0]           claim_id_o,
  output logic                          busy_o,
  output logic [DepthWidth-1:0]         depth_o,
  output logic                          cpl_err_o
);

`ifdef RV_PLIC_TARGET_NEST_EN
  localparam int StackDepth = NEST_DEPTH;
`else
  localparam int StackDepth = 1;
`endif

  logic                  irq_q, irq_d;
  logic [SrcWidth-1:0]   irq_id_q, irq_id_d;
  logic                  cpl_err_q, cpl_err_d;
  logic [DepthWidth-1:0] depth_q, depth_d;
  logic [N_SOURCE-1:0]   inserv_q, inserv_d;
  logic [SrcWidth-1:0]   stack_id_q [StackDepth];
  logic [SrcWidth-1:0]   stack_id_d [StackDepth];

`ifdef RV_PLIC_TARGET_NEST_EN
  logic [PrioWidth-1:0]  stack_prio_q [StackDepth];
  logic [PrioWidth-1:0]  stack_prio_d [StackDepth];
  logic [PrioWidth-1:0]  prio_arr [N_SOURCE];
  logic [PrioWidth-1:0]  top_prio_d;

  for (genvar gi = 0; gi < N_SOURCE; gi++) begin : g_prio
    assign prio_arr[gi] = prio_i[gi*PrioWidth +: PrioWidth];
  end
`endif

  logic [N_SOURCE-1:0]   leaf_valid;
  node_t                 root;
  logic [SrcWidth-1:0]   root_id;
  logic                  root_ok;
  logic [SrcWidth-1:0]   top_id;
  logic                  busy;
  logic                  claim_ok;
  logic                  cpl_ok;
  logic                  push;
  logic [DepthWidth-1:0] depth_pop;
  logic [PrioWidth-1:0]  eff_thr;
  logic                  full_d;

  assign leaf_valid = ip_i & ie_i & ~inserv_q;

  rv_plic_prio_tree #(
    .N_SOURCE   (N_SOURCE),
    .PRIO_W     (PrioWidth),
    .PIPE_EVERY (PIPE_EVERY)
  ) u_tree (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .leaf_valid_i (leaf_valid),
    .leaf_prio_i  (prio_i),
    .root_o       (root)
  );

  always_comb begin
    top_id = '0;
    for (int i = 0; i < StackDepth; i++) begin
      if (depth_q == DepthWidth'(i + 1)) top_id = stack_id_q[i];
    end

    busy     = (depth_q != '0);
    claim_ok = claim_i & irq_q;
    // The top of a non-empty stack is never ID 0, so a complete of ID 0
    // always falls into the error branch.
    cpl_ok    = complete_i & busy & (complete_id_i == top_id);
    cpl_err_d = complete_i & ~cpl_ok;

    // Complete is applied first; a same-cycle claim lands on the popped stack.
    depth_pop = depth_q - DepthWidth'(cpl_ok);
    push      = claim_ok & (depth_pop < DepthWidth'(StackDepth));
    depth_d   = depth_pop + DepthWidth'(push);

    stack_id_d = stack_id_q;
    for (int i = 0; i < StackDepth; i++) begin
      if (push && depth_pop == DepthWidth'(i)) stack_id_d[i] = irq_id_q;
    end

    inserv_d = inserv_q;
    if (cpl_ok) inserv_d[complete_id_i] = 1'b0;
    if (push)   inserv_d[irq_id_q]      = 1'b1;

`ifdef RV_PLIC_TARGET_NEST_EN
    stack_prio_d = stack_prio_q;
    for (int i = 0; i < StackDepth; i++) begin
      if (push && depth_pop == DepthWidth'(i)) stack_prio_d[i] = prio_arr[irq_id_q];
    end
    top_prio_d = '0;
    for (int i = 0; i < StackDepth; i++) begin
      if (depth_d == DepthWidth'(i + 1)) top_prio_d = stack_prio_d[i];
    end
    eff_thr = (top_prio_d > threshold_i) ? top_prio_d : threshold_i;
`else
    eff_thr = threshold_i;
`endif

    full_d = (depth_d == DepthWidth'(StackDepth));

    // Root compare uses the post-update stack and mask, so a just-claimed ID
    // (possibly still in flight inside the tree) cannot re-raise irq.
    root_ok  = root.valid & (root.id < NodeIdW'(N_SOURCE));
    root_id  = root.id[SrcWidth-1:0];
    irq_d    = root_ok & (root.prio > NodePrioW'(eff_thr)) & ~inserv_d[root_id] & ~full_d;
    irq_id_d = root_ok ? root_id : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
      cpl_err_q <= 1'b0;
      depth_q   <= '0;
      inserv_q  <= '0;
      for (int i = 0; i < StackDepth; i++) begin
        stack_id_q[i] <= '0;
`ifdef RV_PLIC_TARGET_NEST_EN
        stack_prio_q[i] <= '0;
`endif
      end
    end else begin
      irq_q      <= irq_d;
      irq_id_q   <= irq_id_d;
      cpl_err_q  <= cpl_err_d;
      depth_q    <= depth_d;
      inserv_q   <= inserv_d;
      stack_id_q <= stack_id_d;
`ifdef RV_PLIC_TARGET_NEST_EN
      stack_prio_q <= stack_prio_d;
`endif
    end
  end

  assign irq_o      = irq_q;
  assign irq_id_o   = irq_id_q;
  assign claim_id_o = claim_ok ? irq_id_q : '0;
  assign busy_o     = busy;
  assign depth_o    = depth_q;
  assign cpl_err_o  = cpl_err_q;

endmodule

// File: doc/rv_plic_target_cc.md
# rv_plic_target_cc

Per-target PLIC arbiter. It selects the highest-priority enabled pending source through a max-tree that can be pipelined, and compares the winner against the target threshold. It also tracks claim/complete, with an in-service stack that allows priority-based nesting. It sits between the per-source gateways and the target's claim/complete CSRs, and drives one external interrupt line of a hart.

## Interface
- N_SOURCE, 32: number of sources. ID 0 is reserved ("no interrupt"), and ip_i[0] is ignored. Must be ≥ 2.
- MAX_PRIO, 7: highest priority. PrioWidth = $clog2(MAX_PRIO+1).
- PIPE_EVERY, 2: a register stage is inserted every PIPE_EVERY tree levels. 0 means a purely combinational tree.
- NEST_DEPTH, 4: in-service stack depth. Must be ≥ 1.
- clk_i, input, 1: clock.
- rst_ni, input, 1: reset, asynchronous, active-low.
- ip_i, input, N_SOURCE: pending bits from the gateways.
- ie_i, input, N_SOURCE: enable bits for this target.
- prio_i, input, N_SOURCE×PrioWidth: per-source priority.
- threshold_i, input, PrioWidth: target threshold.
- claim_i, input, 1: single-cycle claim strobe (CSR read).
- complete_i, input, 1: single-cycle complete strobe (CSR write).
- complete_id_i, input, SrcWidth: ID being completed.
- irq_o, output, 1: registered interrupt request.
- irq_id_o, output, SrcWidth: registered winning ID. It is 0 when no source is pending.
- claim_id_o, output, SrcWidth: claim response. Combinational, valid in the cycle claim_i is high, and 0 otherwise.
- busy_o, output, 1: stack is non-empty.
- depth_o, output, $clog2(NEST_DEPTH+1): stack occupancy.
- cpl_err_o, output, 1: one-cycle pulse when a complete is rejected.

## Operation
- **Leaf qualification:** leaf s is valid when ip_i[s] & ie_i[s] & ~inserv[s]. inserv is the bit-mask of the IDs currently on the stack.
- **Tree selection:** the tree keeps the larger priority at each node. On a priority tie the lower ID wins. A single valid child is forwarded. Invalid leaves carry prio 0 and ID 0.
- **Effective threshold:** eff_thr = max(threshold_i, prio of top-of-stack). With an empty stack, eff_thr = threshold_i.
- **Next-state request:**
  - irq_d = root_valid & (root_prio > eff_thr) & ~inserv[root_id] & ~full.
  - The inserv check at the root discards stale winners still in flight in the pipeline.
- **Next-state ID:** irq_id_d = root_valid ? root_id : 0.
- **Claim:**
  - If claim_i is high and irq_o=1: claim_id_o = irq_id_o. That ID is pushed with its prio_i value, and its inserv bit is set.
  - If claim_i is high and irq_o=0: claim_id_o = 0 and no push happens.
- **Complete:**
  - If complete_i is high and complete_id_i equals the top-of-stack ID: pop and clear its inserv bit.
  - Otherwise, including an empty stack or complete_id_i = 0: the stack is unchanged and cpl_err_o pulses the next cycle.
- **Simultaneous claim and complete:** the complete is evaluated first, against the pre-cycle stack. The claim response uses the pre-cycle irq_o/irq_id_o. The push then lands on the post-pop stack, so occupancy is unchanged and the net effect is a top replacement.
- **Full stack:** when depth_o = NEST_DEPTH, irq_o is forced to 0, so claims return 0.

## Timing
- **Pipeline depth:** L = $clog2(N_SOURCE) levels. The number of stages is P = (PIPE_EVERY==0) ? 0 : (L-1)/PIPE_EVERY, using integer division.
- **Latency:** from ip_i/ie_i/prio_i to irq_o/irq_id_o is P+1 cycles.
- **Threshold path:** threshold_i and stack changes act on the root compare, so they take effect after 1 cycle.
- **Claimed ID drop:** after a claim, irq_o for that ID drops on the next edge. The root inserv check enforces this regardless of P.
- **Reset values:** irq_o=0, irq_id_o=0, claim_id_o=0, busy_o=0, depth_o=0, cpl_err_o=0. All pipeline registers, the stack and inserv are cleared.
- **Reset during nesting:** the stack is discarded and no completes are expected afterwards.
- **Strobe protocol:** claim_i and complete_i are pulses. Holding either for N cycles acts as N strobes.

## Configuration
- RV_PLIC_TARGET_NEST_EN defined:
  - Nesting works as described above.
  - A higher-priority source may be presented and claimed while others are in service.
- RV_PLIC_TARGET_NEST_EN undefined:
  - Stack depth is forced to 1, regardless of NEST_DEPTH.
  - irq_o=0 whenever busy_o=1.
  - eff_thr = threshold_i.

## Structure
- **Package rv_plic_target_pkg:** holds the node struct (valid, id, prio), the width functions, and the stage-count function for P.
- **Sub-module rv_plic_prio_tree:** the parametrised, optionally pipelined max-tree. Inputs are the leaves; outputs are the root struct.
- **Top level:** holds the root compare, output registers, stack, inserv mask and error logic.

## Test plan
- **Pipeline latency:** N_SOURCE=32, PIPE_EVERY=2, threshold 0. Set ip/ie[5] with prio 3. Expect irq_o=1 and irq_id_o=5 exactly P+1 = 3 cycles later.
- **Tie-break and threshold:** sources 7 and 9 both at prio 4, threshold 4 → irq_o=0. Set threshold to 3 → next cycle irq_id_o=7.
- **Nesting:**
  - Claim 7 (prio 4) → claim_id_o=7 and depth_o=1.
  - Source 12 at prio 4 does not fire; source 12 at prio 6 fires.
  - Claim 12 → depth_o=2.
  - Complete 12, then complete 7 → depth_o=0.
- **Complete errors:** complete ID 7 while the top is 12 → cpl_err_o pulses and depth_o is unchanged. Complete on an empty stack → pulse.
- **Simultaneous claim and complete:** stack holds 7 while irq_id_o=12 is pending. Claim and complete(7) in the same cycle → claim_id_o=12, depth_o stays 1, top of stack = 12.
- **Full stack and reset:** fill to NEST_DEPTH → irq_o=0 and claims return 0. Assert rst_ni mid-stack → all outputs 0 at the next observation.
